// File: rtl/chip_select_arbiter_pkg.sv
// rtl/chip_select_arbiter_pkg.sv - shared state encoding and sizing for the '139 chip-select arbiter
package chip_select_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/chip_select_arbiter_rr_pick4.sv
// rtl/chip_select_arbiter_rr_pick4.sv - combinational 4-way round-robin priority picker
module rr_pick4
  import chip_select_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest eligible index wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (eligible[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/chip_select_arbiter.sv
// rtl/chip_select_arbiter.sv - round-robin owner of one '139 decoder half with turnaround and hold limit
module chip_select_arbiter
  import chip_select_arbiter_pkg::*;
#(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  output logic             SEL_A0,
  output logic             SEL_A1,
  output logic             _SEL_E,
  output logic [N_REQ-1:0] _GNT,
  output logic             BUSY,
  output logic             TIMEOUT
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       turn_q, turn_d;
  logic [N_REQ-1:0] lock_q, lock_d;
  logic             sel_e_q, sel_e_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             hold_limit;

  rr_pick4 u_pick (
    .eligible (REQ & ~lock_q),
    .ptr      (ptr_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  assign owner_req  = REQ[sel_q];
  assign hold_limit = (MAX_HOLD != 0) && (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    sel_e_d   = sel_e_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    lock_d    = lock_q & REQ;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          sel_e_d = 1'b0;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        hold_d = hold_q + 8'd1;
        // An owner drop wins over a coinciding hold limit: that is a normal release.
        if (!owner_req || hold_limit) begin
          sel_e_d = 1'b1;
          ptr_d   = sel_q + 2'd1;
          hold_d  = '0;
          if (owner_req) begin
            timeout_d     = 1'b1;
            lock_d[sel_q] = 1'b1;
          end
          if (TURN_CYCLES > 0) begin
            state_d = ST_TURN;
            turn_d  = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      ST_TURN: begin
        if (turn_q == 4'(TURN_CYCLES - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_e_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      hold_q    <= '0;
      turn_q    <= '0;
      lock_q    <= '0;
      sel_e_q   <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      lock_q    <= lock_d;
      sel_e_q   <= sel_e_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign SEL_A0  = sel_q[0];
  assign SEL_A1  = sel_q[1];
  assign _SEL_E  = sel_e_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;
  assign _GNT    = sel_e_q ? 4'hF : ~(4'b0001 << sel_q);

endmodule

// File: tb/tb_chip_select_arbiter.sv
// tb/tb_chip_select_arbiter.sv - directed checks of the chip-select arbiter in three parameter setups
module tb_chip_select_arbiter;

  logic       CLK;
  logic       RST;
  logic [3:0] req  [3];
  logic       sa0  [3];
  logic       sa1  [3];
  logic       se   [3];
  logic [3:0] gnt  [3];
  logic       busy [3];
  logic       to   [3];

  int n_err;
  int n_checks;

  // u0: default setup, u1: hold limit of 4, u2: no turnaround
  chip_select_arbiter #(.TURN_CYCLES(1), .MAX_HOLD(0)) u0 (
    .CLK(CLK), .RST(RST), .REQ(req[0]), .SEL_A0(sa0[0]), .SEL_A1(sa1[0]),
    ._SEL_E(se[0]), ._GNT(gnt[0]), .BUSY(busy[0]), .TIMEOUT(to[0]));
  chip_select_arbiter #(.TURN_CYCLES(1), .MAX_HOLD(4)) u1 (
    .CLK(CLK), .RST(RST), .REQ(req[1]), .SEL_A0(sa0[1]), .SEL_A1(sa1[1]),
    ._SEL_E(se[1]), ._GNT(gnt[1]), .BUSY(busy[1]), .TIMEOUT(to[1]));
  chip_select_arbiter #(.TURN_CYCLES(0), .MAX_HOLD(0)) u2 (
    .CLK(CLK), .RST(RST), .REQ(req[2]), .SEL_A0(sa0[2]), .SEL_A1(sa1[2]),
    ._SEL_E(se[2]), ._GNT(gnt[2]), .BUSY(busy[2]), .TIMEOUT(to[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sel_of(input int i);
    return {sa1[i], sa0[i]};
  endfunction

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    n_err    = 0;
    n_checks = 0;
    RST      = 1'b1;
    for (int i = 0; i < 3; i++) req[i] = 4'h0;
    tick();
    tick();
    RST = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_se%0d", i), 32'(se[i]), 32'd1);
      check($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 32'hF);
      check($sformatf("rst_sel%0d", i), 32'(sel_of(i)), 32'd0);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_to%0d", i), 32'(to[i]), 32'd0);
    end

    // Fairness: all request, each owner holds 3 grant cycles then drops and re-raises
    req[0] = 4'hF;
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 10 && se[0]; w++) tick();
      check($sformatf("rr_wait%0d", k), 32'(se[0]), 32'd0);
      check($sformatf("rr_owner%0d", k), 32'(sel_of(0)), 32'(exp_order[k]));
      tick();
      tick();
      check($sformatf("rr_hold%0d", k), 32'(se[0]), 32'd0);
      req[0][exp_order[k]] = 1'b0;
      tick();
      check($sformatf("rr_rel%0d", k), 32'(se[0]), 32'd1);
      check($sformatf("rr_turn_busy%0d", k), 32'(busy[0]), 32'd1);
      req[0][exp_order[k]] = 1'b1;
    end
    req[0] = 4'h0;
    tick();
    tick();
    tick();

    // Single request on requester 2
    req[0] = 4'b0100;
    tick();
    check("single_sel", 32'(sel_of(0)), 32'd2);
    check("single_se", 32'(se[0]), 32'd0);
    check("single_gnt", 32'(gnt[0]), 32'hB);
    check("single_busy", 32'(busy[0]), 32'd1);
    tick();
    req[0] = 4'h0;
    tick();
    check("single_rel_se", 32'(se[0]), 32'd1);
    check("single_rel_gnt", 32'(gnt[0]), 32'hF);
    check("single_turn_busy", 32'(busy[0]), 32'd1);
    check("single_turn_sel", 32'(sel_of(0)), 32'd2);
    tick();
    check("single_idle_busy", 32'(busy[0]), 32'd0);

    // Timeout on u1 with REQ[1] held
    req[1] = 4'b0010;
    tick();
    check("to_grant_sel", 32'(sel_of(1)), 32'd1);
    check("to_grant_gnt", 32'(gnt[1]), 32'hD);
    tick();
    tick();
    tick();
    check("to_cycle4_se", 32'(se[1]), 32'd0);
    check("to_cycle4_to", 32'(to[1]), 32'd0);
    tick();
    check("to_rel_se", 32'(se[1]), 32'd1);
    check("to_pulse", 32'(to[1]), 32'd1);
    tick();
    check("to_pulse_end", 32'(to[1]), 32'd0);
    for (int w = 0; w < 4; w++) begin
      tick();
      check($sformatf("to_locked%0d", w), 32'(se[1]), 32'd1);
    end
    req[1] = 4'b0000;
    tick();
    req[1] = 4'b0010;
    tick();
    check("to_regrant_se", 32'(se[1]), 32'd0);
    check("to_regrant_sel", 32'(sel_of(1)), 32'd1);

    // Owner drop on the same edge the hold limit would fire
    tick();
    tick();
    tick();
    req[1] = 4'b0000;
    tick();
    check("sim_rel_se", 32'(se[1]), 32'd1);
    check("sim_no_to", 32'(to[1]), 32'd0);
    req[1] = 4'b0010;
    tick();
    tick();
    check("sim_regrant_se", 32'(se[1]), 32'd0);
    check("sim_regrant_sel", 32'(sel_of(1)), 32'd1);

    // No turnaround: handover 0 -> 1 with exactly one enable-high cycle
    req[2] = 4'b0011;
    tick();
    check("t0_first_sel", 32'(sel_of(2)), 32'd0);
    check("t0_first_se", 32'(se[2]), 32'd0);
    req[2] = 4'b0010;
    tick();
    check("t0_gap_se", 32'(se[2]), 32'd1);
    check("t0_gap_busy", 32'(busy[2]), 32'd0);
    tick();
    check("t0_next_se", 32'(se[2]), 32'd0);
    check("t0_next_sel", 32'(sel_of(2)), 32'd1);
    check("t0_next_gnt", 32'(gnt[2]), 32'hD);

    // Asynchronous reset in the middle of a grant
    #2;
    RST = 1'b1;
    #1;
    check("arst_se", 32'(se[2]), 32'd1);
    check("arst_gnt", 32'(gnt[2]), 32'hF);
    check("arst_sel", 32'(sel_of(2)), 32'd0);
    check("arst_busy", 32'(busy[2]), 32'd0);
    check("arst_to", 32'(to[1]), 32'd0);
    check("arst_se_u1", 32'(se[1]), 32'd1);
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) req[i] = 4'h0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
